// File: rtl/interrupt_sequencer_pkg.sv
// Shared processor package: interrupt sequencer state encoding and stack push word format.
package interrupt_sequencer_pkg;

    localparam int PUSH_W  = 16;
    localparam int FLAGS_W = 3;
    localparam int CNT_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PUSH_HI,
        PUSH_LO,
        PUSH_FLG,
        VECTOR,
        ACTIVE
    } int_state_e;

    // CCR {C,N,Z} sits in the low bits of its stack word.
    function automatic logic [PUSH_W-1:0] flag_word(input logic [FLAGS_W-1:0] flags);
        return {{(PUSH_W - FLAGS_W){1'b0}}, flags};
    endfunction

endpackage

// File: rtl/interrupt_sequencer_int_edge_latch.sv
// Samples Int, detects a rising edge against the previous sample and holds it in a
// one-deep pending bit until the sequencer takes it.
module int_edge_latch (
    input  logic Clk,
    input  logic Rst,
    input  logic Int,
    input  logic clear,
    output logic pending
);

    logic int_s;
    logic int_q;

    // NOTE: non-blocking assignments, so int_q picks up the old int_s and the edge compare sees two distinct samples.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            int_s   <= 1'b0;
            int_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            int_s <= Int;
            int_q <= int_s;
            // An edge that arrives while a request is still pending is dropped.
            if (clear) begin
                pending <= 1'b0;
            end else if (int_s && !int_q) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: freeze fetch, drain, push return PC (plus CCR when
// INT_FLAGS_PUSH_EN is defined), strobe the vector into the PC, wait for RTI.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] VECTOR_ADDR  = '0,
    parameter int                DRAIN_CYCLES = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Int,
    input  logic              branch_pending,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [FLAGS_W-1:0] flags_in,
    input  logic              push_ack,
    input  logic              rti_done,
    output logic              freeze,
    output logic              push_req,
    output logic [PUSH_W-1:0] push_data,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_vec,
    output logic              int_active
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    int_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] pc_cap;
    logic              pending;
    logic              take;

`ifdef INT_FLAGS_PUSH_EN
    logic [FLAGS_W-1:0] flags_cap;
`else
    logic unused_flags;
    assign unused_flags = ^flags_in;
`endif

    function automatic logic [PUSH_W-1:0] pc_hi(input logic [ADDR_W-1:0] pc);
        return PUSH_W'(pc >> 16);
    endfunction

    function automatic logic [PUSH_W-1:0] pc_lo(input logic [ADDR_W-1:0] pc);
        return PUSH_W'(pc);
    endfunction

    assign take   = (state == IDLE) && pending;
    assign pc_vec = VECTOR_ADDR;

    int_edge_latch u_edge (
        .Clk     (Clk),
        .Rst     (Rst),
        .Int     (Int),
        .clear   (take),
        .pending (pending)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pc_cap     <= '0;
`ifdef INT_FLAGS_PUSH_EN
            flags_cap  <= '0;
`endif
            freeze     <= 1'b0;
            push_req   <= 1'b0;
            push_data  <= '0;
            pc_load    <= 1'b0;
            int_active <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            case (state)
                IDLE: if (pending) begin
                    state      <= DRAIN;
                    cnt        <= '0;
                    freeze     <= 1'b1;
                    int_active <= 1'b1;
                end
                // The count saturates, so a late branch only stretches the wait.
                DRAIN: begin
                    if (cnt != DRAIN_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (!branch_pending) begin
                        state     <= PUSH_HI;
                        pc_cap    <= pc_in;
`ifdef INT_FLAGS_PUSH_EN
                        flags_cap <= flags_in;
`endif
                        push_req  <= 1'b1;
                        push_data <= pc_hi(pc_in);
                    end
                end
                PUSH_HI: begin
                    push_data <= push_ack ? pc_lo(pc_cap) : pc_hi(pc_cap);
                    if (push_ack) state <= PUSH_LO;
                end
                PUSH_LO: if (push_ack) begin
`ifdef INT_FLAGS_PUSH_EN
                    state     <= PUSH_FLG;
                    push_data <= flag_word(flags_cap);
`else
                    state     <= VECTOR;
                    push_req  <= 1'b0;
                    push_data <= '0;
                    pc_load   <= 1'b1;
`endif
                end
`ifdef INT_FLAGS_PUSH_EN
                PUSH_FLG: if (push_ack) begin
                    state     <= VECTOR;
                    push_req  <= 1'b0;
                    push_data <= '0;
                    pc_load   <= 1'b1;
                end
`endif
                VECTOR: begin
                    state  <= ACTIVE;
                    freeze <= 1'b0;
                end
                ACTIVE: if (rti_done) begin
                    state      <= IDLE;
                    int_active <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    freeze     <= 1'b0;
                    push_req   <= 1'b0;
                    push_data  <= '0;
                    int_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: queue-based reference model compared every cycle,
// directed entry/stall/branch/nesting/reset scenarios, then randomized traffic.
module tb_interrupt_sequencer;

    localparam int          DC  = 3;
    localparam logic [31:0] VEC = 32'h0000_8000;
`ifdef INT_FLAGS_PUSH_EN
    localparam int NWORDS = 3;
    localparam int EXTRA  = 1;
`else
    localparam int NWORDS = 2;
    localparam int EXTRA  = 0;
`endif

    logic        Clk            = 1'b0;
    logic        Rst            = 1'b1;
    logic        Int            = 1'b0;
    logic        branch_pending = 1'b0;
    logic        push_ack       = 1'b1;
    logic        rti_done       = 1'b0;
    logic [31:0] pc_in          = '0;
    logic [2:0]  flags_in       = 3'b101;
    logic        freeze, push_req, pc_load, int_active;
    logic [15:0] push_data;
    logic [31:0] pc_vec;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: Int history, pending flag, busy phases and a queue of words still to push.
    bit          m_s1, m_s2, m_pend, m_busy, m_drain, m_vec, m_act;
    int          m_elapsed;
    logic [15:0] m_q[$];
    logic [15:0] obs[$];

    always #5 Clk = ~Clk;

    interrupt_sequencer #(
        .ADDR_W       (32),
        .VECTOR_ADDR  (VEC),
        .DRAIN_CYCLES (DC)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Int            (Int),
        .branch_pending (branch_pending),
        .pc_in          (pc_in),
        .flags_in       (flags_in),
        .push_ack       (push_ack),
        .rti_done       (rti_done),
        .freeze         (freeze),
        .push_req       (push_req),
        .push_data      (push_data),
        .pc_load        (pc_load),
        .pc_vec         (pc_vec),
        .int_active     (int_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise, take;
        if (Rst) begin
            m_s1 = 0; m_s2 = 0; m_pend = 0; m_busy = 0;
            m_drain = 0; m_vec = 0; m_act = 0; m_elapsed = 0;
            m_q.delete();
        end else begin
            rise = m_s1 && !m_s2;
            take = !m_busy && m_pend;
            m_s2 = m_s1;
            m_s1 = Int;
            if (!m_busy) begin
                if (m_pend) begin
                    m_busy = 1; m_drain = 1; m_elapsed = 0;
                end
            end else if (m_drain) begin
                m_elapsed++;
                if (m_elapsed >= DC && !branch_pending) begin
                    m_drain = 0;
                    m_q.push_back(pc_in[31:16]);
                    m_q.push_back(pc_in[15:0]);
`ifdef INT_FLAGS_PUSH_EN
                    m_q.push_back({13'b0, flags_in});
`endif
                end
            end else if (m_q.size() != 0) begin
                if (push_ack) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_vec = 1;
                end
            end else if (m_vec) begin
                m_vec = 0; m_act = 1;
            end else if (m_act && rti_done) begin
                m_act = 0; m_busy = 0;
            end
            if (take) m_pend = 0;
            else if (rise) m_pend = 1;
        end
    endtask

    // Record accepted pushes (pre-edge values), then advance the model.
    initial forever begin
        @(posedge Clk);
        if (push_req === 1'b1 && push_ack) obs.push_back(push_data);
        model_step();
    end

    initial forever begin
        @(negedge Clk);
        if (cmp_en) begin
            check("freeze",     freeze,     m_busy && !m_act);
            check("int_active", int_active, m_busy);
            check("push_req",   push_req,   m_q.size() != 0);
            check("push_data",  push_data,  (m_q.size() != 0) ? m_q[0] : 16'h0);
            check("pc_load",    pc_load,    m_vec);
            check("pc_vec",     pc_vec,     VEC);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        Rst = 0; Int = 0; branch_pending = 0; push_ack = 1; rti_done = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge Clk);
            drive_idle();
        end
    endtask

    task automatic finish_isr();
        @(negedge Clk);
        drive_idle();
        rti_done = 1;
        cycles(3);
    endtask

    // Cycle k inputs are driven at the negedge before edge k; outputs seen there belong to cycle k.
    task automatic run_seq(input logic [31:0] pc_base, input bit pc_step, input int bp_from,
                           input int bp_to, input int lo_stall, output int lat, output int lo_cyc);
        int stall;
        stall  = lo_stall;
        lat    = -1;
        lo_cyc = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge Clk);
            if (pc_load && lat < 0) lat = k;
            if (push_req && push_data == 16'h1234) lo_cyc++;
            drive_idle();
            Int            = (k == 0);
            branch_pending = (k >= bp_from && k <= bp_to);
            pc_in          = pc_step ? pc_base + 32'(k) : pc_base;
            if (push_req && push_data == 16'h1234 && stall > 0) begin
                push_ack = 0;
                stall--;
            end
        end
    endtask

    task automatic check_words(input logic [15:0] w0, input logic [15:0] w1);
        check("push_count", obs.size(), NWORDS);
        if (obs.size() >= 2) begin
            check("push_word0", obs[0], w0);
            check("push_word1", obs[1], w1);
        end
`ifdef INT_FLAGS_PUSH_EN
        if (obs.size() >= 3) check("push_word2", obs[2], 16'h0005);
`endif
    endtask

    task automatic measure_gap(output int gap, output int loads);
        bit seen;
        seen  = 0;
        gap   = 0;
        loads = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clk);
            if (!seen) begin
                if (int_active) seen = 1;
                else gap++;
            end
            if (pc_load) loads++;
            drive_idle();
        end
    endtask

    initial begin
        int lat, lo_cyc, gap, loads, busy_cnt;
        bit found;

        repeat (3) @(negedge Clk);
        cmp_en = 1;
        check("rst_freeze",     freeze,     0);
        check("rst_push_req",   push_req,   0);
        check("rst_push_data",  push_data,  0);
        check("rst_pc_load",    pc_load,    0);
        check("rst_int_active", int_active, 0);
        check("rst_pc_vec",     pc_vec,     VEC);
        drive_idle();
        cycles(3);

        // Basic entry: ack tied high, no branch.
        obs.delete();
        run_seq(32'h0000_1234, 0, -1, -2, 0, lat, lo_cyc);
        check("latency_basic", lat, DC + 5 + EXTRA);
        check_words(16'h0000, 16'h1234);
        finish_isr();

        // Memory stage stalls the low PC word for four cycles.
        obs.delete();
        run_seq(32'h0000_1234, 0, -1, -2, 4, lat, lo_cyc);
        check("lo_stall_cycles", lo_cyc, 5);
        check("latency_stall", lat, DC + 5 + EXTRA + 4);
        check_words(16'h0000, 16'h1234);
        finish_isr();

        // Branch in flight over the last drain cycle and four more; PC changes every cycle.
        obs.delete();
        run_seq(32'hABCD_0000, 1, 5, 9, 0, lat, lo_cyc);
        check("latency_branch", lat, DC + 5 + EXTRA + 5);
        check_words(16'hABCD, 16'h000A);

        // Second edge while ACTIVE is serviced after RTI.
        obs.delete();
        pc_in = 32'h0000_1234;
        @(negedge Clk);
        drive_idle();
        Int = 1;
        cycles(4);
        @(negedge Clk);
        drive_idle();
        rti_done = 1;
        measure_gap(gap, loads);
        check("nest_idle_gap", gap, 1);
        check("nest_loads", loads, 1);
        check_words(16'h0000, 16'h1234);

        // Edge landing in the same cycle as rti_done.
        @(negedge Clk);
        drive_idle();
        Int = 1;
        @(negedge Clk);
        drive_idle();
        rti_done = 1;
        measure_gap(gap, loads);
        check("same_cycle_gap", gap, 1);
        check("same_cycle_loads", loads, 1);
        finish_isr();

        // Reset while parked in PUSH_HI with a second edge already pending.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge Clk);
            if (push_req) found = 1;
            drive_idle();
            push_ack = 0;
            Int      = (k == 0 || k == 3);
            if (found) Rst = 1;
        end
        check("rst_reached_push", found, 1);
        @(negedge Clk);
        drive_idle();
        check("rst_push_freeze",     freeze,     0);
        check("rst_push_req_low",    push_req,   0);
        check("rst_push_data_zero",  push_data,  0);
        check("rst_push_pc_load",    pc_load,    0);
        check("rst_push_int_active", int_active, 0);
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (int_active || push_req || freeze) busy_cnt++;
            drive_idle();
        end
        check("stale_pending_dropped", busy_cnt, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            if ($urandom_range(0, 4) == 0) Int = ~Int;
            branch_pending = ($urandom_range(0, 2) == 0);
            push_ack       = ($urandom_range(0, 2) != 0);
            rti_done       = ($urandom_range(0, 7) == 0);
            pc_in          = $urandom;
            flags_in       = 3'($urandom_range(0, 7));
            Rst            = ($urandom_range(0, 399) == 0);
        end
        drive_idle();
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, giving PC and vector width in bits.
REQ-002 SHALL have parameter VECTOR_ADDR, default 0, giving the ISR entry address loaded into the PC.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3, giving the pipeline drain wait in cycles, legal range 1..7.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Int, input, 1 bit: external interrupt request, level, sampled each cycle.
REQ-007 SHALL have port branch_pending, input, 1 bit: a taken jump, RET or RTI is in flight.
REQ-008 SHALL have port pc_in, input, ADDR_W bits: return PC, meaning the next unexecuted instruction.
REQ-009 SHALL have port flags_in, input, 3 bits: CCR {C,N,Z}.
REQ-010 SHALL have port push_ack, input, 1 bit: the memory stage accepted the current push word.
REQ-011 SHALL have port rti_done, input, 1 bit: RTI retired in writeback.
REQ-012 SHALL have port freeze, output, 1 bit: hold fetch and insert bubbles into IF/ID.
REQ-013 SHALL have port push_req, output, 1 bit: stack push request.
REQ-014 SHALL have port push_data, output, 16 bits: the word to push.
REQ-015 SHALL have port pc_load, output, 1 bit: a one-cycle strobe that loads the vector into the PC.
REQ-016 SHALL have port pc_vec, output, ADDR_W bits: equal to VECTOR_ADDR.
REQ-017 SHALL have port int_active, output, 1 bit: the ISR is in progress.

Function
REQ-018 SHALL latch a rising edge of Int, detected against a registered copy, into a one-deep pending bit; further edges while pending is set are dropped.
REQ-019 SHALL implement states IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VECTOR and ACTIVE.
REQ-020 SHALL move IDLE->DRAIN the cycle after pending is set, clear pending on that transition, and assert freeze from DRAIN through VECTOR inclusive.
REQ-021 SHALL, in DRAIN, count DRAIN_CYCLES cycles and leave only when the count is done and branch_pending=0; if branch_pending=1 it SHALL hold without restarting the count.
REQ-022 SHALL capture pc_in and flags_in into internal registers on DRAIN exit, and push only these captured values.
REQ-023 SHALL, in each push state, drive push_req=1 with push_data stable until the cycle push_ack=1, then advance the next cycle.
REQ-024 SHALL push in this order: PUSH_HI with captured PC[ADDR_W-1:16], zero-extended, then PUSH_LO with PC[15:0].
REQ-025 SHALL hold push_req=0 outside the push states; push_ack received outside those states SHALL be ignored.
REQ-026 SHALL, in VECTOR, spend exactly one cycle with pc_load=1, then go to ACTIVE.
REQ-027 SHALL assert int_active from DRAIN through ACTIVE inclusive.
REQ-028 SHALL move ACTIVE->IDLE on rti_done=1; rti_done in any other state SHALL be ignored.
REQ-029 SHALL keep an Int edge that arrives while not IDLE in the pending bit, serviced in the cycle after the return to IDLE (no nesting).
REQ-030 SHALL give an Int edge in the same cycle as rti_done the same handling: go to IDLE, then DRAIN next cycle.
REQ-031 SHALL achieve minimum latency, with push_ack tied high and no branch pending, of Int edge to pc_load = DRAIN_CYCLES+5 cycles (+1 with INT_FLAGS_PUSH_EN).

Reset
REQ-032 SHALL, on Rst=1 at a clock edge, force state=IDLE and clear pending, the edge-detect register, the counter and the captured PC and flags.
REQ-033 SHALL hold all outputs at 0 during and after reset, except pc_vec, which is always VECTOR_ADDR.
REQ-034 SHALL, on reset in any state, abandon any push in progress with no further push_req.

Configuration
REQ-035 SHALL, when INT_FLAGS_PUSH_EN is defined, insert PUSH_FLG after PUSH_LO, pushing {13'b0, flags_in captured}.
REQ-036 SHALL, when INT_FLAGS_PUSH_EN is undefined, go PUSH_LO->VECTOR, remove the flags register, and leave PUSH_FLG unreachable.

Structure
REQ-037 SHALL place the state enumeration and the 16-bit push word width in the shared processor package.
REQ-038 SHALL implement the Int rising-edge detector plus pending bit as sub-module int_edge_latch.

Verification
REQ-039 SHALL cover: DRAIN_CYCLES=3, push_ack=1, Int pulse with pc_in=0x00001234 -> push 0x0000 then 0x1234, pc_load exactly 8 cycles after the edge.
REQ-040 SHALL cover: push_ack held low 4 cycles in PUSH_LO -> push_req and push_data=0x1234 stable throughout, one push only.
REQ-041 SHALL cover: branch_pending=1 for 5 cycles during DRAIN -> DRAIN extended 5 cycles, pushed PC is the value at DRAIN exit.
REQ-042 SHALL cover: a second Int edge in ACTIVE, then rti_done -> IDLE for one cycle, then DRAIN, giving a second full sequence.
REQ-043 SHALL cover: Rst during PUSH_HI -> next cycle all outputs 0, state IDLE, and a stale pending edge is not serviced.
REQ-044 SHALL cover: INT_FLAGS_PUSH_EN with flags_in=3'b101 -> third push 0x0005, pc_load one cycle later than without the macro.
